// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ifetch_ctrl_pkg                                                   |
// | Brief  : Shared CPU definitions for the instruction fetch controller:      |
// |          fetch state encoding, reset PC and PC increment.                  |
// | Ports  : none (package)                                                    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package ifetch_ctrl_pkg;

  // Fetch controller state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Byte address of the first fetch after reset
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  // Byte distance between consecutive 32-bit instruction words
  localparam logic [31:0] c_pc_inc = 32'd4;

  // Word-align a byte address by clearing its two low bits
  function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage : ifetch_ctrl_pkg
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ifetch_ctrl                                                       |
// | Brief  : Instruction fetch controller. Drives a combinational instruction  |
// |          ROM from a 32-bit PC and presents one registered instruction per  |
// |          cycle to decode through a valid/ready slot. Supports stall,       |
// |          redirect (flush) and a permanent halt released only by reset.     |
// | Ports  : clk, rst         - clock, synchronous active-high reset           |
// |          start            - begin fetching from IDLE                       |
// |          halt_req         - stop fetching until reset                      |
// |          redirect/_pc     - taken branch/jump and its byte target          |
// |          rom_addr/rom_data- word address to ROM, instruction returned      |
// |          inst/inst_pc     - registered instruction and its byte PC         |
// |          inst_valid/ready - output slot handshake                          |
// |          halted           - HALT state with an empty output slot           |
// |          fetch_count      - instructions captured since reset              |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter int          ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  count_q, count_d;

  logic w_slot_free;
  logic w_unused_rpc;

  // The two low target bits are dropped by word alignment
  assign w_unused_rpc = ^redirect_pc[1:0];

  // The slot can take a new instruction if it is empty or being drained now
  assign w_slot_free = !inst_valid_q || inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    count_d      = count_q;

    unique case (state_q)
      S_IDLE: begin
        // halt_req wins over start: a halted core never fetches
        if (halt_req) begin
          state_d = S_HALT;
        end else if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (redirect) begin
          // Flush the slot even if decode is accepting it this cycle; the
          // redirect target is fetched next, and halt may still be taken.
          inst_valid_d = 1'b0;
          pc_d         = align_word(redirect_pc);
          if (halt_req) begin
            state_d = S_HALT;
          end
        end else if (halt_req) begin
          // No capture; a held instruction stays live until decode takes it
          state_d = S_HALT;
          if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
          end
        end else if (w_slot_free) begin
          inst_d       = rom_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + c_pc_inc;
          count_d      = count_q + 32'd1;
        end
        // Otherwise stalled: everything holds
      end

      S_HALT: begin
        // Only drain the output slot; start and redirect are ignored
        if (inst_valid_q && inst_ready) begin
          inst_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_addr    = pc_q[ROM_AW+1:2];
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == S_HALT) && !inst_valid_q;

endmodule : ifetch_ctrl
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ifetch_ctrl                                                    |
// | Brief  : Self-checking bench for ifetch_ctrl. A behavioural fetch model    |
// |          queues each instruction the controller should deliver; a monitor  |
// |          pops and compares on every accepted handshake and also checks     |
// |          valid, halted, fetch_count and rom_addr each cycle.               |
// | Ports  : none                                                              |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ifetch_ctrl;

  localparam int          ROM_AW   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              halt_req = 1'b0;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic              inst_ready = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_valid;
  logic              halted;
  logic [31:0]       fetch_count;

  always #5 clk = ~clk;

  // ROM word n holds the value n
  assign rom_data = {{(32-ROM_AW){1'b0}}, rom_addr};

  ifetch_ctrl #(
    .RESET_PC (RESET_PC),
    .ROM_AW   (ROM_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          m_state = M_IDLE;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_count = 32'd0;
  bit          m_valid = 1'b0;
  bit          checking = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Word the ROM returns for a byte address (ROM index wraps every 2^ROM_AW words)
  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    return (byte_addr / 32'd4) % (32'd1 << ROM_AW);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural fetch rules applied at each rising edge
  task automatic model_edge(input bit s, input bit h, input bit r,
                            input logic [31:0] rpc, input bit rdy, input bit rs);
    exp_t e;
    if (rs) begin
      m_state = M_IDLE;
      m_pc    = RESET_PC;
      m_count = 32'd0;
      m_valid = 1'b0;
      exp_q.delete();
    end else if (m_state == M_IDLE) begin
      if (h)      m_state = M_HALT;
      else if (s) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (r) begin
        m_valid = 1'b0;
        exp_q.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
        if (h) m_state = M_HALT;
      end else if (h) begin
        m_state = M_HALT;
        if (m_valid && rdy) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        e.pc   = m_pc;
        e.word = rom_word(m_pc);
        exp_q.push_back(e);
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit s, input bit h, input bit r,
                      input logic [31:0] rpc, input bit rdy, input bit rs);
    start       = s;
    halt_req    = h;
    redirect    = r;
    redirect_pc = rpc;
    inst_ready  = rdy;
    rst         = rs;
    @(posedge clk);
    model_edge(s, h, r, rpc, rdy, rs);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, rdy, 1'b0);
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on accepted handshakes
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, (m_state == M_HALT) && !m_valid});
        chk("fetch_count", fetch_count, m_count);
        chk("rom_addr", {{(32-ROM_AW){1'b0}}, rom_addr}, rom_word(m_pc));
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_unexpected: actual inst_pc=0x%08h required=no instruction", inst_pc);
          end else begin
            e = exp_q.pop_front();
            chk("inst", inst, e.word);
            chk("inst_pc", inst_pc, e.pc);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    checking = 1'b1;
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);

    // Sequential fetch with decode always ready
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(3, 1'b1);
    chk("count_after_3", fetch_count, 32'd3);
    run(3, 1'b1);

    // Stall for four cycles, then release
    run(4, 1'b0);
    run(3, 1'b1);

    // Redirect to an unaligned target while stalled
    run(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
    chk("redir_rom_addr", {{(32-ROM_AW){1'b0}}, rom_addr}, 32'd64);
    run(2, 1'b0);
    run(3, 1'b1);

    // ROM address wrap across the top of the ROM
    step(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 1'b1, 1'b0);
    run(4, 1'b1);

    // Halt with a held instruction, then drain; later start/redirect ignored
    run(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    run(3, 1'b0);
    run(2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    run(2, 1'b1);

    // Reset mid-stream, restart from RESET_PC
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
    chk("rst2_inst", inst, 32'd0);
    chk("rst2_inst_pc", inst_pc, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(3, 1'b1);

    // Redirect together with halt_req
    step(1'b0, 1'b1, 1'b1, 32'h0000_0088, 1'b0, 1'b0);
    run(2, 1'b1);

    // halt_req in IDLE, start afterwards ignored
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(2, 1'b1);

    // Randomised traffic
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0,
           $urandom_range(0, 299) == 0,
           ($urandom % 12) == 0,
           $urandom,
           ($urandom % 4) != 0,
           $urandom_range(0, 149) == 0);
    end

    run(2, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ifetch_ctrl
`default_nettype wire

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter ROM_AW, default 10, instruction ROM word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, pulse or level that begins fetching from IDLE.
REQ-006 SHALL have port halt_req, input, 1, request to stop fetching permanently until reset.
REQ-007 SHALL have port redirect, input, 1, branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc, input, 32, byte target of redirect.
REQ-009 SHALL have port rom_addr, output, ROM_AW, word address to the combinational instruction ROM.
REQ-010 SHALL have port rom_data, input, 32, instruction word returned combinationally for rom_addr.
REQ-011 SHALL have port inst, output, 32, registered instruction to decode.
REQ-012 SHALL have port inst_pc, output, 32, byte PC of inst.
REQ-013 SHALL have port inst_valid, output, 1, inst/inst_pc hold a live instruction.
REQ-014 SHALL have port inst_ready, input, 1, decode accepts inst this cycle.
REQ-015 SHALL have port halted, output, 1, fetch stopped and output slot empty.
REQ-016 SHALL have port fetch_count, output, 32, number of instructions captured since reset.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on halt_req; HALT exits only via rst.
REQ-018 SHALL keep a 32-bit pc register; rom_addr SHALL equal pc[ROM_AW+1:2] combinationally at all times.
REQ-019 SHALL define "slot free" as !inst_valid || inst_ready.
REQ-020 In RUN with slot free and no redirect, SHALL capture inst<=rom_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, fetch_count+=1 (single-cycle latency, one instruction per cycle sustained).
REQ-021 In RUN with inst_valid=1 and inst_ready=0, SHALL hold inst, inst_pc, inst_valid, pc unchanged (stall).
REQ-022 When slot accepted (inst_ready=1) and no new capture occurs, SHALL clear inst_valid next cycle.
REQ-023 redirect in RUN SHALL have highest priority: inst_valid<=0 (flush, regardless of inst_ready), pc<={redirect_pc[31:2],2'b00}, no capture and no fetch_count change that cycle.
REQ-024 redirect in IDLE or HALT SHALL be ignored.
REQ-025 redirect and halt_req in the same RUN cycle: redirect's pc update and flush apply, state goes to HALT.
REQ-026 halt_req in RUN without redirect: no capture that cycle; any held instruction stays valid until accepted; no further captures in HALT.
REQ-027 halted SHALL be 1 exactly when state is HALT and inst_valid=0.
REQ-028 pc SHALL wrap modulo 2^32; rom_addr therefore wraps every 2^ROM_AW words (32'h0000_0FFC -> 32'h0000_1000 gives rom_addr 1023 -> 0 at default).
REQ-029 fetch_count SHALL wrap modulo 2^32.
REQ-030 start in RUN or HALT SHALL be ignored; halt_req in IDLE SHALL move to HALT without fetching.

Reset
REQ-031 On rst=1 at a clock edge, from any state and mid-stall: state<=IDLE, pc<=RESET_PC, inst<=0, inst_pc<=0, inst_valid<=0, fetch_count<=0; halted=0 follows.
REQ-032 rst SHALL dominate start, halt_req and redirect in the same cycle.

Structure
REQ-033 State encoding, RESET_PC default and PC increment constant (4) SHALL live in the shared CPU package.
REQ-034 SHALL be a single module with no sub-module; the ROM is instantiated by the parent and connected via rom_addr/rom_data.

Verification
REQ-035 Reset, start, inst_ready=1 constant, ROM word n = n: inst_pc 0,4,8,... on consecutive cycles, inst = 0,1,2,..., fetch_count = 3 after three captures.
REQ-036 inst_valid=1, inst_ready=0 for 4 cycles: inst, inst_pc, rom_addr stable; on ready, next inst_pc = held+4.
REQ-037 redirect with redirect_pc=32'h0000_0103 while stalled: inst_valid=0 next cycle, then inst_pc=32'h100, rom_addr=64.
REQ-038 halt_req with held unaccepted instruction: halted=0 until inst_ready, then halted=1, fetch_count frozen, later redirect/start ignored.
REQ-039 pc from 32'h0000_0FFC: rom_addr 1023 then 0; rst mid-stream: all outputs zero, state IDLE, first post-start inst_pc = RESET_PC.
